// File: rtl/riscv_pkg.sv
// Shared pipeline constants: instruction classes, load/store widths, access checks.
// Pure declarations and combinational helpers; no latency of its own.
// No flow control here; users apply these to their own handshakes.
package riscv_pkg;

    // Instruction classes as decoded by ID and carried through EX
    localparam logic [2:0] I_load  = 3'b000;
    localparam logic [2:0] I_logic = 3'b001;
    localparam logic [2:0] S_type  = 3'b010;
    localparam logic [2:0] R_type  = 3'b011;
    localparam logic [2:0] J_type  = 3'b100;
    localparam logic [2:0] U_type  = 3'b101;
    localparam logic [2:0] I_jump  = 3'b110;
    localparam logic [2:0] B_type  = 3'b111;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    // Access size lives in the low two funct3 bits; bit 2 only selects unsigned loads
    function automatic mem_size_e func_size(input logic [2:0] func);
        case (func[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_mem(input logic [2:0] itype);
        return (itype == I_load) || (itype == S_type);
    endfunction

    function automatic logic func_legal(input logic [2:0] itype, input logic [2:0] func);
        if (itype == I_load)
            return func inside {F_LB, F_LH, F_LW, F_LBU, F_LHU};
        else if (itype == S_type)
            return func inside {F_SB, F_SH, F_SW};
        else
            return 1'b0;
    endfunction

    function automatic logic is_aligned(input logic [2:0] func, input logic [1:0] addr_lo);
        case (func_size(func))
            HALF:    return !addr_lo[0];
            WORD:    return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // True only for a load/store that will actually be sent to memory
    function automatic logic mem_op_ok(input logic [2:0] itype, input logic [2:0] func,
                                       input logic [1:0] addr_lo);
        return is_mem(itype) && func_legal(itype, func) && is_aligned(func, addr_lo);
    endfunction

    // Stores and branches never write the register file
    function automatic logic writes_rd(input logic [2:0] itype);
        return !((itype == S_type) || (itype == B_type));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane select with sign/zero extension.
// Purely combinational, zero cycles.
// No flow control; output follows rdata/address/funct3 directly.
module mem_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half, then extend according to funct3 bit 2
    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (func_size(func))
            BYTE:    data = func[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            HALF:    data = func[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, single-outstanding data-memory access and MEM/WB register.
// Latency: one edge capture->writeback, plus one edge per dmem_ready wait cycle.
// Backpressure: stall holds EX while a request waits, bounded by MAX_WAIT cycles.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT        = 15,
    parameter int unsigned RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ID_EX_type,
    input  logic [2:0]  ID_EX_func,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] EX_MEM_ALUOUT,
    input  logic [31:0] MEM_WB_rs2,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        acc_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    // Reserved parameter carries no function
    if (RESET_PC_UNUSED != 0) begin : g_rsvd
    end

    logic        exm_valid_q, exm_valid_d;
    logic [2:0]  exm_type_q,  exm_type_d;
    logic [2:0]  exm_func_q,  exm_func_d;
    logic [4:0]  exm_rd_q,    exm_rd_d;
    logic [31:0] exm_alu_q,   exm_alu_d;
    logic [31:0] exm_rs2_q,   exm_rs2_d;
    logic [0:0]  state_q,     state_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;
    logic        wb_valid_q,  wb_valid_d;
    logic        wb_we_q,     wb_we_d;
    logic [4:0]  wb_rd_q,     wb_rd_d;
    logic [31:0] wb_data_q,   wb_data_d;
    logic        acc_err_q,   acc_err_d;

    logic        access;
    logic        timeout;
    logic        is_store;
    logic [31:0] load_data;

    mem_load_align u_align (
        .rdata   (dmem_rdata),
        .addr_lo (exm_alu_q[1:0]),
        .func    (exm_func_q),
        .data    (load_data)
    );

    // Handshake control: request follows state, stall until ready or the wait budget runs out
    always_comb begin
        access   = (state_q == S_ACCESS);
        timeout  = access && !dmem_ready && (wait_cnt_q == 8'(MAX_WAIT));
        stall    = access && !dmem_ready && !timeout;
        dmem_req = access;
        is_store = (exm_type_q == S_type);
    end

    // Memory port drive: everything is zero outside ACCESS so the port is quiet when idle
    always_comb begin
        dmem_we    = access && is_store;
        dmem_addr  = access ? {exm_alu_q[31:2], 2'b00} : 32'b0;
        dmem_be    = 4'b0;
        dmem_wdata = 32'b0;
        if (access) begin
            case (func_size(exm_func_q))
                BYTE: begin
                    dmem_be    = 4'b0001 << exm_alu_q[1:0];
                    dmem_wdata = {4{exm_rs2_q[7:0]}};
                end
                HALF: begin
                    dmem_be    = 4'b0011 << exm_alu_q[1:0];
                    dmem_wdata = {2{exm_rs2_q[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = exm_rs2_q;
                end
            endcase
            if (!is_store)
                dmem_wdata = 32'b0;
        end
    end

    // EX/MEM capture and FSM: a new instruction is taken on every non-stalled edge
    always_comb begin
        exm_valid_d = exm_valid_q;
        exm_type_d  = exm_type_q;
        exm_func_d  = exm_func_q;
        exm_rd_d    = exm_rd_q;
        exm_alu_d   = exm_alu_q;
        exm_rs2_d   = exm_rs2_q;
        state_d     = state_q;
        wait_cnt_d  = 8'd0;
        if (stall) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            exm_valid_d = ex_valid;
            exm_type_d  = ID_EX_type;
            exm_func_d  = ID_EX_func;
            exm_rd_d    = ex_rd;
            exm_alu_d   = EX_MEM_ALUOUT;
            exm_rs2_d   = MEM_WB_rs2;
            state_d     = (ex_valid && mem_op_ok(ID_EX_type, ID_EX_func, EX_MEM_ALUOUT[1:0]))
                          ? S_ACCESS : S_IDLE;
        end
    end

    // MEM/WB: retire EX/MEM contents on any non-stalled edge; stalled edges insert a bubble
    always_comb begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'b0;
        acc_err_d  = 1'b0;
        if (!stall && exm_valid_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = exm_rd_q;
            if (is_mem(exm_type_q)) begin
                if (!mem_op_ok(exm_type_q, exm_func_q, exm_alu_q[1:0]) || timeout) begin
                    acc_err_d = 1'b1;
                end else if (exm_type_q == I_load) begin
                    wb_we_d   = (exm_rd_q != 5'd0);
                    wb_data_d = load_data;
                end else begin
                    wb_data_d = exm_alu_q;
                end
            end else begin
                wb_we_d   = writes_rd(exm_type_q) && (exm_rd_q != 5'd0);
                wb_data_d = exm_alu_q;
            end
        end
    end

    // State registers with immediate reset so the request drops without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_valid_q <= 1'b0;
            exm_type_q  <= 3'b0;
            exm_func_q  <= 3'b0;
            exm_rd_q    <= 5'd0;
            exm_alu_q   <= 32'b0;
            exm_rs2_q   <= 32'b0;
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'b0;
            acc_err_q   <= 1'b0;
        end else begin
            exm_valid_q <= exm_valid_d;
            exm_type_q  <= exm_type_d;
            exm_func_q  <= exm_func_d;
            exm_rd_q    <= exm_rd_d;
            exm_alu_q   <= exm_alu_d;
            exm_rs2_q   <= exm_rs2_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            acc_err_q   <= acc_err_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign acc_err  = acc_err_q;

endmodule
